// File: rtl/smem_irq_defer_ctrl.sv
// Defers maskable IRQs while the PC runs inside the protected SW-Att region.
// Optional NMI pass/trap logic is enabled by SMEM_IRQ_DEFER_NMI_EN.
module smem_irq_defer_ctrl #(
  parameter logic [15:0] SMEM_BASE       = 16'hA000,
  parameter logic [15:0] SMEM_SIZE       = 16'h4000,
  parameter int unsigned NIRQ            = 14,
  parameter logic [3:0]  EXIT_DELAY      = 4'd4,
  parameter logic [23:0] MAX_SMEM_CYCLES = 24'hFFFFFF,
  parameter logic [15:0] RESET_HANDLER   = 16'hFFFE
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [15:0]     pc,
  input  logic [NIRQ-1:0] irq_in,
  input  logic [NIRQ-1:0] irq_acc,
`ifdef SMEM_IRQ_DEFER_NMI_EN
  input  logic            nmi_in,
  output logic            nmi_out,
`endif
  output logic [NIRQ-1:0] irq_out,
  output logic            smem_active,
  output logic            pend_any,
  output logic            wdg_reset
);

  localparam logic [15:0] LAST = SMEM_BASE + SMEM_SIZE - 16'd2;

  typedef enum logic [1:0] {
    S_OUT   = 2'd0,
    S_IN    = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          r_state, w_state_n;
  logic [NIRQ-1:0] r_pend, w_pend_n;
  logic [NIRQ-1:0] r_irq, w_irq_n;
  logic [3:0]      r_drain, w_drain_n;
  logic [23:0]     r_cyc, w_cyc_n;
  logic            r_wdg, w_wdg_n;
  logic            r_active, r_pend_any;
  logic            w_in;
  logic            w_nmi_n;
  logic            w_nmi_trap;

  assign w_in = (pc >= SMEM_BASE) && (pc <= LAST);

`ifdef SMEM_IRQ_DEFER_NMI_EN
  logic r_nmi;
  assign w_nmi_trap = nmi_in;
  assign nmi_out    = r_nmi;
`else
  assign w_nmi_trap = 1'b0;
`endif

  always_comb begin
    w_state_n = r_state;
    w_pend_n  = r_pend;
    w_drain_n = r_drain;
    w_cyc_n   = r_cyc;
    w_wdg_n   = r_wdg;
    w_irq_n   = '0;
    w_nmi_n   = 1'b0;
    if (r_wdg && (pc == RESET_HANDLER)) begin
      w_state_n = S_OUT;
      w_pend_n  = '0;
      w_drain_n = '0;
      w_cyc_n   = '0;
      w_wdg_n   = 1'b0;
    end else begin
      unique case (r_state)
        S_OUT: begin
          w_irq_n  = irq_in | r_pend;
          w_nmi_n  = w_nmi_trap;
          // a line still asserted re-arms itself, so ack cannot drop it
          w_pend_n = r_pend & ~(irq_acc & ~irq_in);
          if (w_in) begin
            w_state_n = S_IN;
            w_cyc_n   = '0;
          end
        end
        S_IN: begin
          w_pend_n = r_pend | irq_in;
          if (w_nmi_trap) w_wdg_n = 1'b1;
          if (!w_in) begin
            w_state_n = S_DRAIN;
            w_drain_n = EXIT_DELAY;
            w_cyc_n   = '0;
          end else begin
            if (r_cyc != MAX_SMEM_CYCLES) w_cyc_n = r_cyc + 24'd1;
            if (w_cyc_n == MAX_SMEM_CYCLES) w_wdg_n = 1'b1;
          end
        end
        S_DRAIN: begin
          w_pend_n = r_pend | irq_in;
          if (w_nmi_trap) w_wdg_n = 1'b1;
          if (w_in) begin
            w_state_n = S_IN;
            w_drain_n = '0;
            w_cyc_n   = '0;
          end else if (r_drain <= 4'd1) begin
            w_state_n = S_OUT;
            w_drain_n = '0;
          end else begin
            w_drain_n = r_drain - 4'd1;
          end
        end
        default: begin
          w_state_n = S_OUT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_OUT;
      r_pend     <= '0;
      r_drain    <= '0;
      r_cyc      <= '0;
      r_wdg      <= 1'b0;
      r_irq      <= '0;
      r_active   <= 1'b0;
      r_pend_any <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_pend     <= w_pend_n;
      r_drain    <= w_drain_n;
      r_cyc      <= w_cyc_n;
      r_wdg      <= w_wdg_n;
      r_irq      <= w_irq_n;
      r_active   <= (w_state_n != S_OUT);
      r_pend_any <= |w_pend_n;
    end
  end

`ifdef SMEM_IRQ_DEFER_NMI_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_nmi <= 1'b0;
    else          r_nmi <= w_nmi_n;
  end
`else
  logic w_unused;
  assign w_unused = w_nmi_n;
`endif

  assign irq_out     = r_irq;
  assign smem_active = r_active;
  assign pend_any    = r_pend_any;
  assign wdg_reset   = r_wdg;

endmodule

// File: tb/tb_smem_irq_defer_ctrl.sv
// Directed bench for smem_irq_defer_ctrl (watchdog bound shortened to 16).
module tb_smem_irq_defer_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] pc;
  logic [13:0] irq_in;
  logic [13:0] irq_acc;
  logic [13:0] irq_out;
  logic        smem_active;
  logic        pend_any;
  logic        wdg_reset;
`ifdef SMEM_IRQ_DEFER_NMI_EN
  logic        nmi_in = 1'b0;
  logic        nmi_out;
`endif

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  smem_irq_defer_ctrl #(
    .MAX_SMEM_CYCLES(24'd16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pc         (pc),
    .irq_in     (irq_in),
    .irq_acc    (irq_acc),
`ifdef SMEM_IRQ_DEFER_NMI_EN
    .nmi_in     (nmi_in),
    .nmi_out    (nmi_out),
`endif
    .irq_out    (irq_out),
    .smem_active(smem_active),
    .pend_any   (pend_any),
    .wdg_reset  (wdg_reset)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    pc = 16'h4400;
    irq_in = '0;
    irq_acc = '0;
    #12;
    checks++;
    if (irq_out !== 14'h0) begin
      errs++; $display("FAIL rst_irq_out got=%h exp=0", irq_out);
    end
    checks++;
    if (smem_active !== 1'b0) begin
      errs++; $display("FAIL rst_active got=%b exp=0", smem_active);
    end
    checks++;
    if (pend_any !== 1'b0) begin
      errs++; $display("FAIL rst_pend_any got=%b exp=0", pend_any);
    end
    checks++;
    if (wdg_reset !== 1'b0) begin
      errs++; $display("FAIL rst_wdg got=%b exp=0", wdg_reset);
    end
    @(negedge clk);
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_passthrough();
    pc = 16'h4400;
    irq_in = 14'h0004;
    step();
    checks++;
    if (irq_out !== 14'h0004) begin
      errs++; $display("FAIL pass_irq got=%h exp=0004", irq_out);
    end
    checks++;
    if (smem_active !== 1'b0) begin
      errs++; $display("FAIL pass_active got=%b exp=0", smem_active);
    end
    irq_in = '0;
    step();
    checks++;
    if (irq_out !== 14'h0) begin
      errs++; $display("FAIL pass_drop got=%h exp=0", irq_out);
    end
  endtask

  task automatic test_defer();
    pc = 16'hA000;
    step();
    checks++;
    if (smem_active !== 1'b1) begin
      errs++; $display("FAIL defer_enter got=%b exp=1", smem_active);
    end
    irq_in = 14'h0010;
    step();
    irq_in = '0;
    checks++;
    if (irq_out !== 14'h0 || pend_any !== 1'b1) begin
      errs++;
      $display("FAIL defer_hold irq=%h pend=%b exp 0/1", irq_out, pend_any);
    end
    pc = 16'hE000;
    for (int k = 0; k <= 5; k++) begin
      step();
      checks++;
      if (irq_out !== ((k == 5) ? 14'h0010 : 14'h0)) begin
        errs++; $display("FAIL defer_rel k=%0d got=%h", k, irq_out);
      end
      checks++;
      if (smem_active !== (k < 4)) begin
        errs++; $display("FAIL defer_act k=%0d got=%b", k, smem_active);
      end
    end
  endtask

  task automatic test_ack();
    irq_in = 14'h0010;
    irq_acc = 14'h0010;
    step();
    checks++;
    if (pend_any !== 1'b1) begin
      errs++; $display("FAIL ack_setwins got=%b exp=1", pend_any);
    end
    irq_in = '0;
    irq_acc = '0;
    step();
    checks++;
    if (irq_out !== 14'h0010) begin
      errs++; $display("FAIL ack_still got=%h exp=0010", irq_out);
    end
    irq_acc = 14'h0010;
    step();
    irq_acc = '0;
    checks++;
    if (pend_any !== 1'b0) begin
      errs++; $display("FAIL ack_clear got=%b exp=0", pend_any);
    end
    step();
    checks++;
    if (irq_out !== 14'h0) begin
      errs++; $display("FAIL ack_out got=%h exp=0", irq_out);
    end
  endtask

  task automatic test_reenter();
    pc = 16'hA000;
    step();
    irq_in = 14'h0020;
    irq_acc = 14'h0020;
    step();
    irq_in = '0;
    pc = 16'hE000;
    step();
    irq_acc = '0;
    step();
    pc = 16'hA100;
    step();
    checks++;
    if (smem_active !== 1'b1 || irq_out !== 14'h0 || pend_any !== 1'b1) begin
      errs++;
      $display("FAIL reent act=%b irq=%h pend=%b exp 1/0/1",
               smem_active, irq_out, pend_any);
    end
    pc = 16'hE000;
    for (int k = 0; k <= 5; k++) begin
      step();
      checks++;
      if (irq_out !== ((k == 5) ? 14'h0020 : 14'h0)) begin
        errs++; $display("FAIL reent_rel k=%0d got=%h", k, irq_out);
      end
    end
    irq_acc = 14'h0020;
    step();
    irq_acc = '0;
    step();
    checks++;
    if (pend_any !== 1'b0 || irq_out !== 14'h0) begin
      errs++;
      $display("FAIL reent_clr pend=%b irq=%h exp 0/0", pend_any, irq_out);
    end
  endtask

  task automatic test_watchdog();
    pc = 16'hA002;
    step();
    for (int k = 1; k <= 16; k++) begin
      irq_in = (k == 1) ? 14'h0001 : 14'h0;
      step();
      checks++;
      if (wdg_reset !== (k == 16)) begin
        errs++; $display("FAIL wdg_rise k=%0d got=%b", k, wdg_reset);
      end
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (wdg_reset !== 1'b1) begin
        errs++; $display("FAIL wdg_sticky k=%0d got=%b exp=1", k, wdg_reset);
      end
    end
    pc = 16'hFFFE;
    step();
    checks++;
    if (wdg_reset !== 1'b0 || pend_any !== 1'b0 ||
        smem_active !== 1'b0 || irq_out !== 14'h0) begin
      errs++;
      $display("FAIL wdg_clear wdg=%b pend=%b act=%b irq=%h exp 0/0/0/0",
               wdg_reset, pend_any, smem_active, irq_out);
    end
    pc = 16'h4400;
    step();
    checks++;
    if (irq_out !== 14'h0) begin
      errs++; $display("FAIL wdg_after got=%h exp=0", irq_out);
    end
  endtask

  task automatic test_async_reset();
    pc = 16'hA000;
    step();
    irq_in = 14'h0003;
    step();
    irq_in = '0;
    checks++;
    if (pend_any !== 1'b1 || smem_active !== 1'b1) begin
      errs++;
      $display("FAIL ar_pre pend=%b act=%b exp 1/1", pend_any, smem_active);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (pend_any !== 1'b0 || smem_active !== 1'b0 ||
        irq_out !== 14'h0 || wdg_reset !== 1'b0) begin
      errs++;
      $display("FAIL ar_async pend=%b act=%b irq=%h wdg=%b exp 0",
               pend_any, smem_active, irq_out, wdg_reset);
    end
    pc = 16'h4400;
    @(negedge clk);
    reset_n = 1'b1;
    step();
    checks++;
    if (irq_out !== 14'h0 || pend_any !== 1'b0) begin
      errs++;
      $display("FAIL ar_replay irq=%h pend=%b exp 0/0", irq_out, pend_any);
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_defer();
    test_ack();
    test_reenter();
    test_watchdog();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
